// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: FIFO-buffered single-byte command launcher for I2C_driver
// Define I2C_TIMEOUT_EN to abort a command after TIMEOUT_CYCLES clk cycles.
// Ports: cmd_* host command valid/ready in; rsp_* read-byte or timeout response out;
//        drv_* start/rw/addr/data to the driver, busy/rdata back from it;
//        pending = FIFO occupancy; seq_idle = FIFO empty with no command in flight.
module i2c_cmd_sequencer #(
    parameter int DEPTH = 4
`ifdef I2C_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_timeout,
    output logic                     drv_start,
    output logic                     drv_rw,
    output logic [6:0]               drv_addr,
    output logic [7:0]               drv_data,
    input  logic                     drv_busy,
    input  logic [7:0]               drv_rdata,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     seq_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drv_start_q, drv_start_d, drv_rw_q, drv_rw_d;
    logic [6:0]    drv_addr_q, drv_addr_d;
    logic [7:0]    drv_data_q, drv_data_d, rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          push, pop;
`ifdef I2C_TIMEOUT_EN
    logic [31:0]   tmo_cnt_q, tmo_cnt_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          tmo_hit;
`endif

    assign cmd_ready = count_q < CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    // A launch needs a free response slot and an idle driver, whatever the command type.
    assign pop       = state_q == IDLE && count_q != '0 && !rsp_valid_q && !drv_busy;
    assign pending   = count_q;
    assign seq_idle  = state_q == IDLE && count_q == '0;
    assign drv_start = drv_start_q;
    assign drv_rw    = drv_rw_q;
    assign drv_addr  = drv_addr_q;
    assign drv_data  = drv_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef I2C_TIMEOUT_EN
    assign tmo_hit     = state_q != IDLE && tmo_cnt_q + 32'd1 == TIMEOUT_CYCLES;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        drv_start_d = drv_start_q;
        drv_rw_d    = drv_rw_q;
        drv_addr_d  = drv_addr_q;
        drv_data_d  = drv_data_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
`ifdef I2C_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q && !(rsp_valid_q && rsp_ready);
        tmo_cnt_d     = pop ? '0 : state_q != IDLE ? tmo_cnt_q + 32'd1 : tmo_cnt_q;
`endif
        if (pop) begin
            {drv_rw_d, drv_addr_d, drv_data_d} = mem_q[rd_ptr_q];
            drv_start_d = 1'b1;
            state_d     = LAUNCH;
        end else if (state_q == LAUNCH && drv_busy) begin
            drv_start_d = 1'b0;
            state_d     = WAIT_DONE;
        end else if (state_q == WAIT_DONE && !drv_busy) begin
            state_d = IDLE;
            if (drv_rw_q) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = drv_rdata;
`ifdef I2C_TIMEOUT_EN
                rsp_timeout_d = 1'b0;
`endif
            end
        end
`ifdef I2C_TIMEOUT_EN
        // Abort overrides whatever the driver is doing; the next pop still waits for busy=0.
        if (tmo_hit) begin
            drv_start_d   = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_data_d    = 8'hFF;
            state_d       = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drv_start_q <= 1'b0;
            drv_rw_q    <= 1'b0;
            drv_addr_q  <= '0;
            drv_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drv_start_q <= drv_start_d;
            drv_rw_q    <= drv_rw_d;
            drv_addr_q  <= drv_addr_d;
            drv_data_q  <= drv_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
            if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_data};
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed scenarios plus a randomized scoreboard run for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int PW = $clog2(DEPTH) + 1;

    typedef struct packed {logic rw; logic [6:0] a; logic [7:0] d;} cmd_t;

    logic          clk = 0, rst_n = 0;
    logic          cmd_valid = 0, cmd_rw = 0, rsp_ready = 0, drv_busy = 0;
    logic [6:0]    cmd_addr = 0;
    logic [7:0]    cmd_data = 0, drv_rdata = 0;
    logic          cmd_ready, rsp_valid, rsp_timeout, drv_start, drv_rw, seq_idle;
    logic [7:0]    rsp_data, drv_data;
    logic [6:0]    drv_addr;
    logic [PW-1:0] pending;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .DEPTH(DEPTH)
`ifdef I2C_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .drv_start(drv_start), .drv_rw(drv_rw), .drv_addr(drv_addr), .drv_data(drv_data),
        .drv_busy(drv_busy), .drv_rdata(drv_rdata),
        .pending(pending), .seq_idle(seq_idle)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_one(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!drv_start && n < 200) begin tick(); n++; end
        checks++;
        if (drv_start !== 1'b1) begin
            failures++;
            $display("FAIL %s: drv_start=%b, required 1 within 200 cycles", name, drv_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; rsp_ready = 0; drv_busy = 0;
        tick();
        checks++;
        if (cmd_ready !== 1 || seq_idle !== 1 || pending !== 0) begin
            failures++;
            $display("FAIL reset_status: cmd_ready=%b seq_idle=%b pending=%0d, required 1 1 0", cmd_ready, seq_idle, pending);
        end
        checks++;
        if ({drv_start, drv_rw, drv_addr, drv_data} !== 16'h0) begin
            failures++;
            $display("FAIL reset_drv: start=%b rw=%b addr=%h data=%h, required all 0", drv_start, drv_rw, drv_addr, drv_data);
        end
        checks++;
        if (rsp_valid !== 0 || rsp_data !== 0 || rsp_timeout !== 0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b data=%h timeout=%b, required 0 00 0", rsp_valid, rsp_data, rsp_timeout);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write();
        int bad = 0;
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h50; cmd_data = 8'hA5;
        tick();
        cmd_valid = 0;
        checks++;
        if (drv_start !== 0 || pending !== 1) begin
            failures++;
            $display("FAIL write_after_push: drv_start=%b pending=%0d, required 0 1", drv_start, pending);
        end
        tick();
        checks++;
        if (drv_start !== 1 || drv_rw !== 0 || drv_addr !== 7'h50 || drv_data !== 8'hA5 || pending !== 0) begin
            failures++;
            $display("FAIL write_launch: start=%b rw=%b addr=%h data=%h pending=%0d, required 1 0 50 a5 0",
                     drv_start, drv_rw, drv_addr, drv_data, pending);
        end
        drv_busy = 1;
        tick();
        checks++;
        if (drv_start !== 0 || drv_addr !== 7'h50 || drv_data !== 8'hA5) begin
            failures++;
            $display("FAIL write_start_drop: start=%b addr=%h data=%h, required 0 50 a5", drv_start, drv_addr, drv_data);
        end
        tick();
        drv_busy = 0;
        repeat (4) begin tick(); if (rsp_valid !== 0) bad++; end
        checks++;
        if (bad != 0 || seq_idle !== 1) begin
            failures++;
            $display("FAIL write_no_rsp: rsp_valid cycles=%0d seq_idle=%b, required 0 1", bad, seq_idle);
        end
    endtask

    task automatic test_read();
        push_one(1, 7'h3C, 8'h00);
        wait_start("read_start");
        checks++;
        if (drv_rw !== 1 || drv_addr !== 7'h3C) begin
            failures++;
            $display("FAIL read_launch: rw=%b addr=%h, required 1 3c", drv_rw, drv_addr);
        end
        drv_busy = 1;
        repeat (2) tick();
        drv_rdata = 8'h5A; drv_busy = 0;
        tick();
        checks++;
        if (rsp_valid !== 1 || rsp_data !== 8'h5A || rsp_timeout !== 0) begin
            failures++;
            $display("FAIL read_rsp: valid=%b data=%h timeout=%b, required 1 5a 0", rsp_valid, rsp_data, rsp_timeout);
        end
        tick();
        checks++;
        if (rsp_valid !== 1 || rsp_data !== 8'h5A) begin
            failures++;
            $display("FAIL read_rsp_hold: valid=%b data=%h, required 1 5a", rsp_valid, rsp_data);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 0) begin
            failures++;
            $display("FAIL read_rsp_clear: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_full();
        int idx = 0, n = 0;
        bit acc, stall = 1;
        logic [6:0] log_a[$];
        logic [7:0] log_d[$];
        while ((idx < 5 || log_a.size() < 5) && n < 300) begin
            if (drv_start && !drv_busy) begin
                log_a.push_back(drv_addr); log_d.push_back(drv_data); drv_busy = 1;
            end else if (drv_busy && !stall) drv_busy = 0;
            if (idx == 5 && stall) begin
                checks++;
                if (pending !== 4 || cmd_ready !== 0) begin
                    failures++;
                    $display("FAIL full_status: pending=%0d cmd_ready=%b, required 4 0", pending, cmd_ready);
                end
                stall = 0;
            end
            cmd_valid = idx < 5; cmd_rw = 0; cmd_addr = 7'(64 + idx); cmd_data = 8'(192 + idx);
            acc = cmd_valid && cmd_ready;
            tick(); n++;
            if (acc) idx++;
        end
        cmd_valid = 0;
        tick();
        drv_busy = 0;
        repeat (2) tick();
        checks++;
        if (log_a.size() != 5) begin
            failures++;
            $display("FAIL full_launch_count: launches=%0d, required 5", log_a.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_a[i] !== 7'(64 + i) || log_d[i] !== 8'(192 + i)) begin
                    failures++;
                    $display("FAIL full_order[%0d]: addr=%h data=%h, required %h %h", i, log_a[i], log_d[i], 7'(64 + i), 8'(192 + i));
                end
            end
        end
    endtask

    task automatic test_rsp_block();
        int starts = 0;
        push_one(1, 7'h11, 8'h00);
        push_one(0, 7'h22, 8'h33);
        wait_start("block_read_start");
        checks++;
        if (drv_addr !== 7'h11 || drv_rw !== 1) begin
            failures++;
            $display("FAIL block_read_launch: addr=%h rw=%b, required 11 1", drv_addr, drv_rw);
        end
        drv_busy = 1;
        tick();
        drv_rdata = 8'h77; drv_busy = 0;
        tick();
        repeat (10) begin tick(); if (drv_start) starts++; end
        checks++;
        if (starts != 0 || pending !== 1 || rsp_valid !== 1 || rsp_data !== 8'h77) begin
            failures++;
            $display("FAIL block_hold: starts=%0d pending=%0d rsp_valid=%b rsp_data=%h, required 0 1 1 77",
                     starts, pending, rsp_valid, rsp_data);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 0 || drv_start !== 0) begin
            failures++;
            $display("FAIL block_consume: rsp_valid=%b drv_start=%b, required 0 0", rsp_valid, drv_start);
        end
        tick();
        checks++;
        if (drv_start !== 1 || drv_addr !== 7'h22 || drv_data !== 8'h33 || drv_rw !== 0) begin
            failures++;
            $display("FAIL block_write_launch: start=%b addr=%h data=%h rw=%b, required 1 22 33 0",
                     drv_start, drv_addr, drv_data, drv_rw);
        end
        drv_busy = 1;
        tick();
        drv_busy = 0;
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 0 || seq_idle !== 1) begin
            failures++;
            $display("FAIL block_write_done: rsp_valid=%b seq_idle=%b, required 0 1", rsp_valid, seq_idle);
        end
    endtask

    task automatic test_reset_mid();
        push_one(0, 7'h0F, 8'h01);
        wait_start("rst_launch_start");
        #2 rst_n = 0;
        #1;
        checks++;
        if (drv_start !== 0 || drv_addr !== 0 || drv_data !== 0) begin
            failures++;
            $display("FAIL rst_in_launch: start=%b addr=%h data=%h, required 0 00 00", drv_start, drv_addr, drv_data);
        end
        tick();
        rst_n = 1;
        tick();
        push_one(0, 7'h61, 8'h11);
        push_one(0, 7'h62, 8'h12);
        push_one(0, 7'h63, 8'h13);
        wait_start("rst_wait_start");
        drv_busy = 1;
        repeat (2) tick();
        checks++;
        if (pending !== 2 || drv_addr !== 7'h61 || drv_start !== 0) begin
            failures++;
            $display("FAIL rst_pre: pending=%0d addr=%h start=%b, required 2 61 0", pending, drv_addr, drv_start);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (drv_start !== 0 || pending !== 0 || rsp_valid !== 0 || drv_addr !== 0 || seq_idle !== 1 || cmd_ready !== 1) begin
            failures++;
            $display("FAIL rst_async: start=%b pending=%0d rsp_valid=%b addr=%h seq_idle=%b cmd_ready=%b, required 0 0 0 00 1 1",
                     drv_start, pending, rsp_valid, drv_addr, seq_idle, cmd_ready);
        end
        drv_busy = 0;
        tick();
        rst_n = 1;
        repeat (5) tick();
        checks++;
        if (drv_start !== 0 || pending !== 0) begin
            failures++;
            $display("FAIL rst_lost_queue: start=%b pending=%0d, required 0 0", drv_start, pending);
        end
    endtask

`ifdef I2C_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0, starts = 0;
        push_one(0, 7'h2A, 8'h01);
        wait_start("tmo_start");
        drv_busy = 1;
        while (!rsp_valid && k < 300) begin tick(); k++; end
        checks++;
        if (k != 100 || rsp_timeout !== 1 || rsp_data !== 8'hFF || drv_start !== 0) begin
            failures++;
            $display("FAIL tmo_rsp: cycles=%0d timeout=%b data=%h start=%b, required 100 1 ff 0", k, rsp_timeout, rsp_data, drv_start);
        end
        push_one(0, 7'h2B, 8'h02);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        repeat (5) begin tick(); if (drv_start) starts++; end
        checks++;
        if (starts != 0 || rsp_valid !== 0) begin
            failures++;
            $display("FAIL tmo_busy_block: starts=%0d rsp_valid=%b, required 0 0", starts, rsp_valid);
        end
        drv_busy = 0;
        wait_start("tmo_next_start");
        checks++;
        if (drv_addr !== 7'h2B) begin
            failures++;
            $display("FAIL tmo_next_launch: addr=%h, required 2b", drv_addr);
        end
        drv_busy = 1;
        tick();
        drv_busy = 0;
        repeat (3) tick();
    endtask
`endif

    // Reference: model FIFO of accepted commands, launches must follow it in order,
    // only after a cycle with no pending response; reads produce the byte the driver returned.
    task automatic test_random();
        cmd_t mq[$];
        cmd_t cur = '0, pc = '0;
        logic [7:0] exp_rsp[$];
        int to_send = 80, bst = 0, cnt = 0, n = 0;
        bit inflight = 0, clr = 0, push_s = 0, prev_rv = 0, hs;
        while ((to_send > 0 || cmd_valid || mq.size() > 0 || inflight || exp_rsp.size() > 0 || rsp_valid) && n < 5000) begin
            if (push_s) begin mq.push_back(pc); cmd_valid = 0; end
            if (clr) inflight = 0;
            push_s = 0; clr = 0;
            if (bst == 0 && drv_start) begin
                checks++;
                if (mq.size() == 0 || prev_rv || {drv_rw, drv_addr, drv_data} !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_launch: got %h prev_rsp_valid=%b, required %h with no pending response",
                             {drv_rw, drv_addr, drv_data}, prev_rv, mq.size() ? mq[0] : cmd_t'(0));
                end
                cur = mq.size() ? mq.pop_front() : cmd_t'(0);
                inflight = 1; cnt = $urandom_range(0, 2); bst = 1;
            end
            if (bst == 1) begin
                if (cnt == 0) begin
                    checks++;
                    if ({drv_rw, drv_addr, drv_data} !== cur || drv_start !== 1) begin
                        failures++;
                        $display("FAIL rand_stable: got %h start=%b, required %h 1", {drv_rw, drv_addr, drv_data}, drv_start, cur);
                    end
                    drv_busy = 1; cnt = $urandom_range(1, 4); bst = 2;
                end else cnt--;
            end else if (bst == 2) begin
                cnt--;
                if (cnt == 0) begin
                    drv_busy = 0; drv_rdata = 8'($urandom);
                    if (cur.rw) exp_rsp.push_back(drv_rdata);
                    clr = 1; bst = 0;
                end
            end
            checks++;
            if (pending !== PW'(mq.size()) || cmd_ready !== (mq.size() < DEPTH) || seq_idle !== (mq.size() == 0 && !inflight)) begin
                failures++;
                $display("FAIL rand_status: pending=%0d cmd_ready=%b seq_idle=%b, required %0d %b %b",
                         pending, cmd_ready, seq_idle, mq.size(), mq.size() < DEPTH, mq.size() == 0 && !inflight);
            end
            rsp_ready = $urandom_range(0, 2) != 0;
            hs = rsp_valid && rsp_ready;
            if (hs) begin
                checks++;
                if (exp_rsp.size() == 0 || rsp_data !== exp_rsp[0] || rsp_timeout !== 0) begin
                    failures++;
                    $display("FAIL rand_rsp: data=%h timeout=%b, required %h 0 (expected queue size %0d)",
                             rsp_data, rsp_timeout, exp_rsp.size() ? exp_rsp[0] : 8'h00, exp_rsp.size());
                end
                if (exp_rsp.size() > 0) void'(exp_rsp.pop_front());
            end
            if (!cmd_valid && to_send > 0 && $urandom_range(0, 1) == 1) begin
                cmd_valid = 1; cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
                to_send--;
            end
            if (cmd_valid && cmd_ready) begin push_s = 1; pc = {cmd_rw, cmd_addr, cmd_data}; end
            prev_rv = rsp_valid;
            tick(); n++;
        end
        cmd_valid = 0; rsp_ready = 0; drv_busy = 0;
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL rand_drain: cycles=%0d, required completion before 5000", n);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_rsp_block();
        test_reset_mid();
`ifdef I2C_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
